// File: rtl/disp7seg_scan_ctrl.sv
// disp7seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// Double-buffered digit image, committed atomically at frame wrap.
module disp7seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_mask,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    state_t                r_state;
    logic [DW-1:0]         r_act_data;
    logic [NUM_DIGITS-1:0] r_act_mask;
    logic [DW-1:0]         r_shd_data;
    logic [NUM_DIGITS-1:0] r_shd_mask;
    logic                  r_pending;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_fd;

    logic                  w_slot_end;
    logic                  w_wrap;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    state_t                w_state_nxt;
    logic [DW-1:0]         w_act_data_nxt;
    logic [NUM_DIGITS-1:0] w_act_mask_nxt;
    logic [DW-1:0]         w_shd_data_nxt;
    logic [NUM_DIGITS-1:0] w_shd_mask_nxt;
    logic                  w_pending_nxt;
    logic [3:0]            w_digit;
    logic                  w_on;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [6:0]            w_seg_nxt;
    logic                  w_fd_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] h);
        logic [6:0] s;
        s = 7'b0000000;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Slot counter and digit index advance; frame wraps on last slot's last cycle
    always_comb begin
        w_slot_end = (r_cnt == C_LAST);
        w_wrap     = w_slot_end && (r_idx == I_LAST);
        w_cnt_nxt  = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_nxt  = r_idx;
        if (w_slot_end) begin
            w_idx_nxt = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Next state follows the post-edge counter so pins carry zero latency
    always_comb begin
        w_state_nxt = (w_cnt_nxt < C_BLANK) ? ST_BLANK : ST_SHOW;
    end

    // State register: counter, index and scan phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= ST_BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Shadow capture and frame-boundary commit; a load on the wrap cycle bypasses
    always_comb begin
        w_act_data_nxt = r_act_data;
        w_act_mask_nxt = r_act_mask;
        w_shd_data_nxt = r_shd_data;
        w_shd_mask_nxt = r_shd_mask;
        w_pending_nxt  = r_pending;
        if (load) begin
            w_shd_data_nxt = load_data;
            w_shd_mask_nxt = load_mask;
            w_pending_nxt  = 1'b1;
        end
        if (w_wrap) begin
            if (load) begin
                w_act_data_nxt = load_data;
                w_act_mask_nxt = load_mask;
            end else if (r_pending) begin
                w_act_data_nxt = r_shd_data;
                w_act_mask_nxt = r_shd_mask;
            end
            w_pending_nxt = 1'b0;
        end
    end

    // Active and shadow buffer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_data <= '0;
            r_act_mask <= '0;
            r_shd_data <= '0;
            r_shd_mask <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_act_data <= w_act_data_nxt;
            r_act_mask <= w_act_mask_nxt;
            r_shd_data <= w_shd_data_nxt;
            r_shd_mask <= w_shd_mask_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    // Output decode from post-edge state, index and buffer contents
    always_comb begin
        w_digit  = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_on     = (w_state_nxt == ST_SHOW) && w_act_mask_nxt[w_idx_nxt];
        w_an_nxt = '0;
        if (w_on) begin
            w_an_nxt[w_idx_nxt] = 1'b1;
        end
        w_seg_nxt = w_on ? f_decode(w_digit) : 7'b0000000;
        w_fd_nxt  = (w_cnt_nxt == C_LAST) && (w_idx_nxt == I_LAST);
    end

    // Registered display pins and frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= '0;
            r_seg <= '0;
            r_fd  <= 1'b0;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_fd  <= w_fd_nxt;
        end
    end

    assign pending    = r_pending;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_disp7seg_scan_ctrl.sv
// tb_disp7seg_scan_ctrl: frame-level directed vectors for the scan
// controller with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_disp7seg_scan_ctrl;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] SF = 7'b1110001;
    localparam logic [6:0] SZ = 7'b0000000;

    typedef struct {
        logic        pend0;
        int          last;
        logic [3:0]  dmask;
        logic [27:0] dseg;
        int          la;
        logic [15:0] da;
        logic [3:0]  ma;
        int          lb;
        logic [15:0] db;
        logic [3:0]  mb;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_data;
    logic [3:0]  load_mask;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int nvec;
    int nerr;
    vec_t tbl [8];

    disp7seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_mask (load_mask),
        .pending   (pending),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] ea,
                         input logic [6:0] es, input logic ep,
                         input logic ef);
        nvec++;
        if (an !== ea || seg !== es || pending !== ep || frame_done !== ef) begin
            nerr++;
            $display("FAIL %s: got an=%b seg=%b pend=%b fd=%b want an=%b seg=%b pend=%b fd=%b",
                     nm, an, seg, pending, frame_done, ea, es, ep, ef);
        end
    endtask

    task automatic run_frame(input int vi, input vec_t v);
        logic       m_pend;
        int         cnt;
        int         idx;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        m_pend = v.pend0;
        for (int p = 0; p < v.last; p++) begin
            cnt   = p % 8;
            idx   = p / 8;
            e_an  = 4'b0000;
            e_seg = SZ;
            if (cnt >= 2 && v.dmask[idx]) begin
                e_an  = 4'b0001 << idx;
                e_seg = v.dseg[idx*7 +: 7];
            end
            check($sformatf("v%0d p%0d", vi, p), e_an, e_seg, m_pend, p == 31);
            load = 1'b0;
            if (p == v.la) begin
                load      = 1'b1;
                load_data = v.da;
                load_mask = v.ma;
            end
            if (p == v.lb) begin
                load      = 1'b1;
                load_data = v.db;
                load_mask = v.mb;
            end
            if (load && p != 31) m_pend = 1'b1;
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        reset     = 1'b1;
        load      = 1'b0;
        load_data = 16'h0000;
        load_mask = 4'b0000;

        // idle frame, no load
        tbl[0] = '{1'b0, 32, 4'b0000, 28'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0};
        // load 1234 mid-frame, display still dark
        tbl[1] = '{1'b0, 32, 4'b0000, 28'h0, 5, 16'h1234, 4'hF, -1, 16'h0, 4'h0};
        // shows 1234 (digit0 = nibble 4); load 00F8/0101
        tbl[2] = '{1'b0, 32, 4'b1111, {S1, S2, S3, S4},
                   10, 16'h00F8, 4'b0101, -1, 16'h0, 4'h0};
        // shows 8 on slot0, 0 on slot2; two loads, last wins
        tbl[3] = '{1'b0, 32, 4'b0101, {SZ, S0, SZ, S8},
                   3, 16'hAAAA, 4'hF, 20, 16'h5555, 4'hF};
        // shows 5555; load FFFF on the frame_done cycle
        tbl[4] = '{1'b0, 32, 4'b1111, {S5, S5, S5, S5},
                   31, 16'hFFFF, 4'hF, -1, 16'h0, 4'h0};
        // shows FFFF; load 1234 then stop at slot2 cnt4
        tbl[5] = '{1'b0, 20, 4'b1111, {SF, SF, SF, SF},
                   10, 16'h1234, 4'hF, -1, 16'h0, 4'h0};
        // after mid-frame reset: dark, old shadow never appears
        tbl[6] = '{1'b0, 32, 4'b0000, 28'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0};
        tbl[7] = '{1'b0, 32, 4'b0000, 28'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0};

        repeat (3) tick();
        check("reset held", 4'b0000, SZ, 1'b0, 1'b0);
        tick();
        check("reset held 2", 4'b0000, SZ, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(i, tbl[i]);

        check("slot2 cnt4 pre-reset", 4'b0100, SF, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async reset", 4'b0000, SZ, 1'b0, 1'b0);
        tick();
        check("reset hold edge", 4'b0000, SZ, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        for (int i = 6; i < 8; i++) run_frame(i, tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
